// File: rtl/sdram_burst_scheduler.sv
// Burst scheduler in front of sdram_control: round-robin write/read
// arbitration, linear burst pointers, occupancy tracking and watchdog.
module sdram_burst_scheduler #(
    parameter int BURST     = 8,
    parameter int COL_BITS  = 9,
    parameter int ROW_BITS  = 13,
    parameter int BANK_BITS = 2,
    parameter int DEPTH     = 1 << (COL_BITS + ROW_BITS + BANK_BITS),
    parameter int TIMEOUT   = 1023
) (
    input  logic                                       Clk,
    input  logic                                       Rst_n,
    input  logic                                       Init_done,
    input  logic                                       Wr_req,
    input  logic                                       Rd_req,
    input  logic                                       Addr_clr,
    input  logic                                       Wdata_done,
    input  logic                                       Rdata_done,
    output logic                                       Wr,
    output logic                                       Rd,
    output logic [ROW_BITS-1:0]                        Raddr,
    output logic [ROW_BITS-1:0]                        Caddr,
    output logic [BANK_BITS-1:0]                       Baddr,
    output logic                                       Wr_burst_done,
    output logic                                       Rd_burst_done,
    output logic [COL_BITS+ROW_BITS+BANK_BITS:0]       Fill,
    output logic                                       Busy,
    output logic                                       Err
);

    localparam int W   = COL_BITS + ROW_BITS + BANK_BITS;
    localparam int WDW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WR_WAIT = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;

    localparam logic LAST_WR = 1'b0;
    localparam logic LAST_RD = 1'b1;

    localparam logic [W:0]     BW   = (W+1)'(BURST);
    localparam logic [W:0]     DP   = (W+1)'(DEPTH);
    localparam logic [W:0]     FMAX = (W+1)'(DEPTH - BURST);
    localparam logic [WDW-1:0] TMO  = WDW'(TIMEOUT);

    logic [1:0]     state_q, state_d;
    logic [W-1:0]   wptr_q, wptr_d;
    logic [W-1:0]   rptr_q, rptr_d;
    logic [W-1:0]   addr_q, addr_d;
    logic [W:0]     fill_q, fill_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           last_q, last_d;
    logic           clr_q, clr_d;
    logic           err_q, err_d;
    logic           wbd_q, wbd_d;
    logic           rbd_q, rbd_d;

    logic           clr_any;
    logic           w_elig;
    logic           r_elig;
    logic [W-1:0]   wnext;
    logic [W-1:0]   rnext;

    function automatic logic [W-1:0] adv(input logic [W-1:0] p);
        logic [W:0] s;
        s = {1'b0, p} + BW;
        return (s == DP) ? '0 : s[W-1:0];
    endfunction

    assign clr_any = clr_q | Addr_clr;
    assign w_elig  = Wr_req & Init_done & (fill_q <= FMAX) & ~clr_any;
    assign r_elig  = Rd_req & Init_done & (fill_q >= BW) & ~clr_any;
    assign wnext   = adv(wptr_q);
    assign rnext   = adv(rptr_q);

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        addr_d  = addr_q;
        fill_d  = fill_q;
        wdog_d  = wdog_q;
        last_d  = last_q;
        clr_d   = clr_q;
        err_d   = err_q;
        wbd_d   = 1'b0;
        rbd_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Addr_clr) begin
                    wptr_d = '0;
                    rptr_d = '0;
                    addr_d = '0;
                    fill_d = '0;
                    err_d  = 1'b0;
                    clr_d  = 1'b0;
                end else if (w_elig && (!r_elig || last_q == LAST_RD)) begin
                    state_d = WR_WAIT;
                    last_d  = LAST_WR;
                    wdog_d  = '0;
                    addr_d  = wptr_q;
                end else if (r_elig) begin
                    state_d = RD_WAIT;
                    last_d  = LAST_RD;
                    wdog_d  = '0;
                    addr_d  = rptr_q;
                end
            end
            WR_WAIT, RD_WAIT: begin
                logic done;
                done = (state_q == WR_WAIT) ? Wdata_done : Rdata_done;
                if (Addr_clr) clr_d = 1'b1;
                if (done || wdog_q == TMO) begin
                    state_d = IDLE;
                    // A clear pending at exit wins over both completion and timeout
                    if (clr_any) begin
                        wptr_d = '0;
                        rptr_d = '0;
                        addr_d = '0;
                        fill_d = '0;
                        err_d  = 1'b0;
                        clr_d  = 1'b0;
                    end else if (!done) begin
                        err_d = 1'b1;
                    end else if (state_q == WR_WAIT) begin
                        wptr_d = wnext;
                        addr_d = wnext;
                        fill_d = fill_q + BW;
                        wbd_d  = 1'b1;
                    end else begin
                        rptr_d = rnext;
                        addr_d = rnext;
                        fill_d = fill_q - BW;
                        rbd_d  = 1'b1;
                    end
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            addr_q  <= '0;
            fill_q  <= '0;
            wdog_q  <= '0;
            last_q  <= LAST_RD;
            clr_q   <= 1'b0;
            err_q   <= 1'b0;
            wbd_q   <= 1'b0;
            rbd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            addr_q  <= addr_d;
            fill_q  <= fill_d;
            wdog_q  <= wdog_d;
            last_q  <= last_d;
            clr_q   <= clr_d;
            err_q   <= err_d;
            wbd_q   <= wbd_d;
            rbd_q   <= rbd_d;
        end
    end

    assign Wr            = (state_q == WR_WAIT);
    assign Rd            = (state_q == RD_WAIT);
    assign Busy          = (state_q != IDLE);
    assign Caddr         = ROW_BITS'(addr_q[COL_BITS-1:0]);
    assign Raddr         = addr_q[COL_BITS+ROW_BITS-1:COL_BITS];
    assign Baddr         = addr_q[W-1:COL_BITS+ROW_BITS];
    assign Fill          = fill_q;
    assign Err           = err_q;
    assign Wr_burst_done = wbd_q;
    assign Rd_burst_done = rbd_q;

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Directed bench for sdram_burst_scheduler: vector table plus
// hand-written multi-cycle sequences (wrap, guards, timeout, clear).
module tb_sdram_burst_scheduler;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Init_done = 1'b0;
    logic        Wr_req = 1'b0;
    logic        Rd_req = 1'b0;
    logic        Addr_clr = 1'b0;
    logic        Wdata_done = 1'b0;
    logic        Rdata_done = 1'b0;
    logic        Wr, Rd;
    logic [12:0] Raddr, Caddr;
    logic [1:0]  Baddr;
    logic        Wr_burst_done, Rd_burst_done;
    logic [24:0] Fill;
    logic        Busy, Err;

    int n_cmp = 0;
    int n_bad = 0;

    sdram_burst_scheduler #(
        .DEPTH   (64),
        .TIMEOUT (15)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Init_done     (Init_done),
        .Wr_req        (Wr_req),
        .Rd_req        (Rd_req),
        .Addr_clr      (Addr_clr),
        .Wdata_done    (Wdata_done),
        .Rdata_done    (Rdata_done),
        .Wr            (Wr),
        .Rd            (Rd),
        .Raddr         (Raddr),
        .Caddr         (Caddr),
        .Baddr         (Baddr),
        .Wr_burst_done (Wr_burst_done),
        .Rd_burst_done (Rd_burst_done),
        .Fill          (Fill),
        .Busy          (Busy),
        .Err           (Err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic ini, wq, rq, wd, rdn;
        logic ewr, erd, ewbd, erbd;
        int   ecol, efill;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(
        logic ini, logic wq, logic rq, logic wd, logic rdn,
        logic ewr, logic erd, logic ewbd, logic erbd,
        int ecol, int efill);
        vec_t v;
        v.ini = ini; v.wq = wq; v.rq = rq; v.wd = wd; v.rdn = rdn;
        v.ewr = ewr; v.erd = erd; v.ewbd = ewbd; v.erbd = erbd;
        v.ecol = ecol; v.efill = efill;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr_burst(input int cur, input int nxt, input int fl);
        Wr_req = 1'b1;
        tick();
        Wr_req = 1'b0;
        chk("wr_grant", {31'd0, Wr}, 1);
        chk("wr_caddr", {19'd0, Caddr}, cur);
        Wdata_done = 1'b1;
        tick();
        Wdata_done = 1'b0;
        chk("wr_low", {31'd0, Wr}, 0);
        chk("wr_bdone", {31'd0, Wr_burst_done}, 1);
        chk("wr_next", {19'd0, Caddr}, nxt);
        chk("wr_fill", {7'd0, Fill}, fl);
    endtask

    task automatic rd_burst(input int cur, input int nxt, input int fl);
        Rd_req = 1'b1;
        tick();
        Rd_req = 1'b0;
        chk("rd_grant", {31'd0, Rd}, 1);
        chk("rd_caddr", {19'd0, Caddr}, cur);
        Rdata_done = 1'b1;
        tick();
        Rdata_done = 1'b0;
        chk("rd_bdone", {31'd0, Rd_burst_done}, 1);
        chk("rd_next", {19'd0, Caddr}, nxt);
        chk("rd_fill", {7'd0, Fill}, fl);
    endtask

    initial begin
        int cnt;
        int blocked;

        //              ini wq rq wd rd  wr rd wb rb col fill
        tbl[0]  = mk(0, 1, 0, 0, 0,  0, 0, 0, 0,  0,  0);
        tbl[1]  = mk(1, 1, 0, 0, 0,  1, 0, 0, 0,  0,  0);
        tbl[2]  = mk(1, 1, 0, 0, 0,  1, 0, 0, 0,  0,  0);
        tbl[3]  = mk(1, 0, 0, 1, 0,  0, 0, 1, 0,  8,  8);
        tbl[4]  = mk(1, 1, 0, 0, 0,  1, 0, 0, 0,  8,  8);
        tbl[5]  = mk(1, 0, 0, 1, 0,  0, 0, 1, 0, 16, 16);
        tbl[6]  = mk(1, 1, 1, 0, 0,  0, 1, 0, 0,  0, 16);
        tbl[7]  = mk(1, 1, 1, 0, 1,  0, 0, 0, 1,  8,  8);
        tbl[8]  = mk(1, 1, 1, 0, 0,  1, 0, 0, 0, 16,  8);
        tbl[9]  = mk(1, 1, 1, 1, 1,  0, 0, 1, 0, 24, 16);
        tbl[10] = mk(1, 1, 1, 0, 0,  0, 1, 0, 0,  8, 16);
        tbl[11] = mk(1, 1, 1, 1, 1,  0, 0, 0, 1, 16,  8);
        tbl[12] = mk(1, 1, 1, 0, 0,  1, 0, 0, 0, 24,  8);
        tbl[13] = mk(1, 0, 0, 1, 0,  0, 0, 1, 0, 32, 16);
        tbl[14] = mk(1, 0, 0, 1, 0,  0, 0, 0, 0, 32, 16);

        tick();
        chk("rst_wr", {31'd0, Wr}, 0);
        chk("rst_rd", {31'd0, Rd}, 0);
        chk("rst_busy", {31'd0, Busy}, 0);
        chk("rst_err", {31'd0, Err}, 0);
        chk("rst_fill", {7'd0, Fill}, 0);
        chk("rst_addr", {17'd0, Baddr, Raddr}, 0);
        Rst_n = 1'b1;
        tick();

        for (int i = 0; i < 15; i++) begin
            Init_done  = tbl[i].ini;
            Wr_req     = tbl[i].wq;
            Rd_req     = tbl[i].rq;
            Wdata_done = tbl[i].wd;
            Rdata_done = tbl[i].rdn;
            tick();
            chk($sformatf("v%0d_wr", i), {31'd0, Wr}, {31'd0, tbl[i].ewr});
            chk($sformatf("v%0d_rd", i), {31'd0, Rd}, {31'd0, tbl[i].erd});
            chk($sformatf("v%0d_busy", i), {31'd0, Busy},
                {31'd0, tbl[i].ewr | tbl[i].erd});
            chk($sformatf("v%0d_wbd", i), {31'd0, Wr_burst_done},
                {31'd0, tbl[i].ewbd});
            chk($sformatf("v%0d_rbd", i), {31'd0, Rd_burst_done},
                {31'd0, tbl[i].erbd});
            chk($sformatf("v%0d_col", i), {19'd0, Caddr}, tbl[i].ecol);
            chk($sformatf("v%0d_fill", i), {7'd0, Fill}, tbl[i].efill);
        end
        Wdata_done = 1'b0;
        Rdata_done = 1'b0;

        rd_burst(16, 24, 8);
        rd_burst(24, 32, 0);
        Rd_req = 1'b1;
        blocked = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (Rd) blocked++;
        end
        Rd_req = 1'b0;
        chk("empty_rd_block", blocked, 0);

        wr_burst(32, 40, 8);
        wr_burst(40, 48, 16);
        wr_burst(48, 56, 24);
        wr_burst(56, 0, 32);
        chk("wrap_raddr", {19'd0, Raddr}, 0);
        chk("wrap_baddr", {30'd0, Baddr}, 0);
        wr_burst(0, 8, 40);
        wr_burst(8, 16, 48);
        wr_burst(16, 24, 56);
        wr_burst(24, 32, 64);
        Wr_req = 1'b1;
        blocked = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (Wr) blocked++;
        end
        Wr_req = 1'b0;
        chk("full_wr_block", blocked, 0);
        chk("full_fill", {7'd0, Fill}, 64);

        rd_burst(32, 40, 56);
        Wr_req = 1'b1;
        tick();
        Wr_req = 1'b0;
        chk("tmo_grant", {31'd0, Wr}, 1);
        cnt = 0;
        while (Wr && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("tmo_cycles", cnt, 16);
        chk("tmo_err", {31'd0, Err}, 1);
        chk("tmo_wbd", {31'd0, Wr_burst_done}, 0);
        chk("tmo_fill", {7'd0, Fill}, 56);
        chk("tmo_caddr", {19'd0, Caddr}, 32);
        wr_burst(32, 40, 64);
        chk("err_sticky", {31'd0, Err}, 1);

        rd_burst(40, 48, 56);
        Wr_req = 1'b1;
        tick();
        chk("clr_grant", {31'd0, Wr}, 1);
        chk("clr_caddr", {19'd0, Caddr}, 40);
        Addr_clr = 1'b1;
        tick();
        Addr_clr = 1'b0;
        chk("clr_hold", {31'd0, Wr}, 1);
        tick();
        Wdata_done = 1'b1;
        tick();
        Wdata_done = 1'b0;
        chk("clr_exit", {31'd0, Wr}, 0);
        chk("clr_wbd", {31'd0, Wr_burst_done}, 0);
        chk("clr_fill", {7'd0, Fill}, 0);
        chk("clr_err", {31'd0, Err}, 0);
        chk("clr_caddr0", {19'd0, Caddr}, 0);
        tick();
        Wr_req = 1'b0;
        chk("clr_regrant", {31'd0, Wr}, 1);
        chk("clr_wptr0", {19'd0, Caddr}, 0);
        Wdata_done = 1'b1;
        tick();
        Wdata_done = 1'b0;
        chk("clr_fill8", {7'd0, Fill}, 8);

        Addr_clr = 1'b1;
        Wr_req   = 1'b1;
        tick();
        Addr_clr = 1'b0;
        chk("iclr_nogrant", {31'd0, Wr}, 0);
        chk("iclr_fill", {7'd0, Fill}, 0);
        tick();
        Wr_req = 1'b0;
        chk("rst_pre", {31'd0, Wr}, 1);
        Rst_n = 1'b0;
        #1;
        chk("rst_async_wr", {31'd0, Wr}, 0);
        chk("rst_async_busy", {31'd0, Busy}, 0);
        Rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
